// File: rtl/cnn_psum_pkg.sv
// Shared defaults and helpers for the partial-sum accumulation engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package cnn_psum_pkg;

    localparam int MULT_WIDTH_DEF     = 14;
    localparam int PSUM_WIDTH_DEF     = 32;
    localparam int PSUM_DEPTH_DEF     = 32;
    localparam int ADDR_WIDTH_DEF     = $clog2(PSUM_DEPTH_DEF);
    localparam int OUT_FIFO_DEPTH_DEF = 4;

    // Finished-sum queue entry at the default widths; the engine declares the
    // same layout locally so it follows its own parameter overrides.
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0]        addr;
        logic signed [PSUM_WIDTH_DEF-1:0] sum;
    } psum_entry_t;

    // Saturation limits for a signed accumulator of width w (w <= 63).
    function automatic longint sat_max_of(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min_of(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/psum_accum_engine_if.sv
// Product-in / finished-sum-out handshake bundle of the psum engine.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates products, out_ready gates finished sums.
interface psum_accum_engine_if #(
    parameter int MULT_WIDTH = 14,
    parameter int PSUM_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [MULT_WIDTH-1:0] in_data;
    logic                         in_first;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [PSUM_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0]        out_addr;

    // Producer of products and consumer of finished sums.
    modport master (
        output in_valid, in_data, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    // The accumulation engine.
    modport slave (
        input  in_valid, in_data, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/psum_out_fifo.sv
// Synchronous FIFO with occupancy count, used as the finished-sum queue.
// Latency: a push is visible at the head one edge later; pop is same-cycle head read.
// Backpressure: pushes on full and pops on empty are ignored; clear empties it.
module psum_out_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop && !empty;

    // Storage array; contents are don't-care once popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (!clear && push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers and occupancy; clear wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/psum_accum_engine.sv
// Pipelined partial-sum accumulator: products in, finished sums out via a small queue.
// Latency: out_valid two edges after accepting a last product (queue empty).
// Backpressure: in_ready drops when queue count plus S1 occupancy reaches OUT_FIFO_DEPTH.
// Build option: define PSUM_SATURATE_EN for a saturating add with sticky overflow.
module psum_accum_engine
    import cnn_psum_pkg::*;
#(
    parameter int MULT_WIDTH     = MULT_WIDTH_DEF,
    parameter int PSUM_WIDTH     = PSUM_WIDTH_DEF,
    parameter int PSUM_DEPTH     = PSUM_DEPTH_DEF,
    parameter int ADDR_WIDTH     = $clog2(PSUM_DEPTH),
    parameter int SIZE_WIDTH     = $clog2(PSUM_DEPTH + 1),
    parameter int OUT_FIFO_DEPTH = OUT_FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE_WIDTH-1:0] psum_size,
    input  logic                  clear,
    psum_accum_engine_if.slave    bus,
    output logic                  block_done,
    output logic                  cfg_error,
    output logic                  overflow
);
    localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        addr;
        logic signed [PSUM_WIDTH-1:0] sum;
    } entry_t;

    // Write pointer into the scratch pad
    logic [ADDR_WIDTH-1:0]        ptr_q, ptr_d;
    logic                         ptr_at_end;

    // S1 stage: the accepted product waiting for its read-modify-write
    logic                         s1_vld_q;
    logic signed [MULT_WIDTH-1:0] s1_dat_q;
    logic [ADDR_WIDTH-1:0]        s1_addr_q;
    logic                         s1_first_q;
    logic                         s1_last_q;

    // Scratch pad and S2 datapath
    logic signed [PSUM_WIDTH-1:0] spad_q [PSUM_DEPTH];
    logic signed [PSUM_WIDTH-1:0] base;
    logic signed [PSUM_WIDTH-1:0] sum;

    // Output queue
    entry_t                       push_entry;
    entry_t                       head;
    logic                         fifo_empty;
    logic [CW-1:0]                fifo_count;
    logic [CW:0]                  occupancy;
    logic                         push;
    logic                         pop;
    logic                         accept;
    logic                         block_done_q, block_done_d;

    assign cfg_error  = (psum_size == '0) || (psum_size > SIZE_WIDTH'(PSUM_DEPTH));
    // No credit for a same-cycle pop: keeps in_ready off the out_ready path.
    assign occupancy  = (CW + 1)'(fifo_count) + (CW + 1)'(s1_vld_q);
    assign bus.in_ready = !cfg_error && (occupancy < (CW + 1)'(OUT_FIFO_DEPTH));
    assign accept     = bus.in_valid && bus.in_ready;
    assign ptr_at_end = (SIZE_WIDTH'(ptr_q) == (psum_size - SIZE_WIDTH'(1)));

    // Pointer advance: wraps after psum_size products, restarts on clear
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (accept) begin
            ptr_d = ptr_at_end ? '0 : ptr_q + ADDR_WIDTH'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    // S1 capture of the accepted product; clear drops it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            s1_addr_q  <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_vld_q <= accept && !clear;
            if (accept) begin
                s1_dat_q   <= bus.in_data;
                s1_addr_q  <= ptr_q;
                s1_first_q <= bus.in_first;
                s1_last_q  <= bus.in_last;
            end
        end
    end

    // S2 read side: first product of a sum starts from zero
    always_comb begin
        base = '0;
        if (!s1_first_q) base = spad_q[s1_addr_q];
    end

`ifdef PSUM_SATURATE_EN
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'(sat_max_of(PSUM_WIDTH));
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = PSUM_WIDTH'(sat_min_of(PSUM_WIDTH));

    logic signed [PSUM_WIDTH:0] wide_sum;
    logic                       clip;
    logic                       overflow_q, overflow_d;

    // Saturating add: one guard bit exposes signed overflow
    always_comb begin
        wide_sum = (PSUM_WIDTH + 1)'(base) + (PSUM_WIDTH + 1)'(s1_dat_q);
        clip     = wide_sum[PSUM_WIDTH] ^ wide_sum[PSUM_WIDTH-1];
        sum      = wide_sum[PSUM_WIDTH-1:0];
        if (clip) sum = wide_sum[PSUM_WIDTH] ? SAT_MIN : SAT_MAX;
    end

    // Sticky overflow: set by any clipped add, cleared only by clear or reset
    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (s1_vld_q && clip) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow_q <= 1'b0;
        else      overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`else
    // Wrapping add modulo 2^PSUM_WIDTH
    always_comb begin
        sum = base + PSUM_WIDTH'(s1_dat_q);
    end

    assign overflow = 1'b0;
`endif

    // S2 write-back; the next S1 reads the updated entry, so no stall is needed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PSUM_DEPTH; i++) spad_q[i] <= '0;
        end else if (s1_vld_q && !clear) begin
            spad_q[s1_addr_q] <= sum;
        end
    end

    assign push            = s1_vld_q && s1_last_q;
    assign push_entry.addr = s1_addr_q;
    assign push_entry.sum  = sum;
    assign pop             = bus.out_valid && bus.out_ready;

    psum_out_fifo #(
        .WIDTH (ADDR_WIDTH + PSUM_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Outputs read as zero while the queue is empty
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : head.sum;
    assign bus.out_addr  = fifo_empty ? '0 : head.addr;

    // Block completion: popping the last live entry
    always_comb begin
        block_done_d = pop && !clear &&
                       (SIZE_WIDTH'(head.addr) == (psum_size - SIZE_WIDTH'(1)));
    end

    // Block-done pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) block_done_q <= 1'b0;
        else      block_done_q <= block_done_d;
    end

    assign block_done = block_done_q;
endmodule

// File: tb/tb_psum_accum_engine.sv
// Self-checking bench for psum_accum_engine with a scoreboard of expected sums.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_psum_accum_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] psum_size = 6'd4;
    logic [2:0] size8 = 3'd1;
    logic       block_done, cfg_error, overflow;
    logic       block_done8, cfg_error8, overflow8;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int bd_cnt   = 0;

    typedef struct {
        int          addr;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    psum_accum_engine_if #(.MULT_WIDTH(14), .PSUM_WIDTH(32), .ADDR_WIDTH(5)) ifc ();
    psum_accum_engine_if #(.MULT_WIDTH(8),  .PSUM_WIDTH(8),  .ADDR_WIDTH(2)) ifc8 ();

    psum_accum_engine #(
        .MULT_WIDTH(14), .PSUM_WIDTH(32), .PSUM_DEPTH(32), .OUT_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .psum_size(psum_size), .clear(clear), .bus(ifc),
        .block_done(block_done), .cfg_error(cfg_error), .overflow(overflow)
    );

    psum_accum_engine #(
        .MULT_WIDTH(8), .PSUM_WIDTH(8), .PSUM_DEPTH(4), .OUT_FIFO_DEPTH(4)
    ) dut8 (
        .clk(clk), .rst(rst), .psum_size(size8), .clear(clear), .bus(ifc8),
        .block_done(block_done8), .cfg_error(cfg_error8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pop the DUT is about to take is checked against the queue head
    always @(negedge clk) begin
        if (rst && !clear && ifc.out_valid && ifc.out_ready) begin
            chk_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got addr %0d data %0h, expected no output",
                         ifc.out_addr, ifc.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(ifc.out_addr) !== e.addr || ifc.out_data !== e.dat)
                    $display("FAIL sb_pop: got (%0d,%0h) expected (%0d,%0h)",
                             ifc.out_addr, ifc.out_data, e.addr, e.dat);
                else
                    pass_cnt++;
            end
        end
        if (rst && block_done) bd_cnt++;
    end

    task automatic push_exp(input int a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.dat  = d;
        sb.push_back(e);
    endtask

    // Drive one product and hold it until accepted; returns the number of stall cycles
    task automatic send(input int d, input logic f, input logic l, output int stalls);
        int n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 14'(d);
        ifc.in_first = f;
        ifc.in_last  = l;
        @(negedge clk);
        while (!ifc.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ifc.in_ready) begin
            chk_cnt++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        stalls = n;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: %0d results outstanding, expected 0", nm, sb.size());
        else
            pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifc.in_valid = 0; ifc.in_data = '0; ifc.in_first = 0; ifc.in_last = 0; ifc.out_ready = 0;
        ifc8.in_valid = 0; ifc8.in_data = '0; ifc8.in_first = 0; ifc8.in_last = 0; ifc8.out_ready = 1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", ifc.out_valid); else pass_cnt++;
        chk_cnt++; if (ifc.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", ifc.in_ready); else pass_cnt++;
        chk_cnt++; if (block_done !== 1'b0) $display("FAIL rst_block_done: got %b expected 0", block_done); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", overflow); else pass_cnt++;
        chk_cnt++; if (ifc.out_data !== 32'h0) $display("FAIL rst_out_data: got %0h expected 0", ifc.out_data); else pass_cnt++;
        chk_cnt++; if (ifc.out_addr !== 5'h0) $display("FAIL rst_out_addr: got %0h expected 0", ifc.out_addr); else pass_cnt++;
        chk_cnt++; if (cfg_error !== 1'b0) $display("FAIL rst_cfg_error: got %b expected 0", cfg_error); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_accumulate();
        int st;
        psum_size = 6'd4;
        ifc.out_ready = 1'b1;
        bd_cnt = 0;
        for (int i = 1; i <= 4; i++) send(i, 1'b1, 1'b0, st);
        for (int i = 1; i <= 4; i++) begin
            push_exp(i - 1, 32'(11 * i));
            send(10 * i, 1'b0, 1'b1, st);
        end
        wait_drain("accumulate");
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bd_cnt !== 1) $display("FAIL block_done_count: got %0d expected 1", bd_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int st;
        int total_st = 0;
        psum_size = 6'd1;
        ifc.out_ready = 1'b1;
        push_exp(0, 32'd15);
        for (int i = 0; i < 5; i++) begin
            send(3, (i == 0), (i == 4), st);
            total_st += st;
        end
        chk_cnt++;
        if (total_st !== 0) $display("FAIL b2b_stalls: got %0d stall cycles expected 0", total_st); else pass_cnt++;
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        int st;
        psum_size = 6'd8;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(i, 32'(i * 1000 - 3000));
            send(i * 1000 - 3000, 1'b1, 1'b1, st);
        end
        @(negedge clk);
        chk_cnt++;
        if (ifc.in_ready !== 1'b1) $display("FAIL bp_ready_at3: got %b expected 1", ifc.in_ready); else pass_cnt++;
        push_exp(3, 32'(3 * 1000 - 3000));
        @(posedge clk); #1;
        send(3 * 1000 - 3000, 1'b1, 1'b1, st);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (ifc.in_ready !== 1'b0) $display("FAIL bp_ready_full: cycle %0d got %b expected 0", c, ifc.in_ready); else pass_cnt++;
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            push_exp(i, 32'(i * 1000 - 3000));
            send(i * 1000 - 3000, 1'b1, 1'b1, st);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_signed();
        int st;
        psum_size = 6'd1;
        ifc.out_ready = 1'b1;
        push_exp(0, 32'hFFFF_FFFD);
        send(-5, 1'b1, 1'b0, st);
        send(2, 1'b0, 1'b1, st);
        wait_drain("signed");
    endtask

    task automatic test_saturate();
        int n = 0;
        logic [7:0] exp_d;
        logic       exp_ov;
`ifdef PSUM_SATURATE_EN
        exp_d = 8'd127; exp_ov = 1'b1;
`else
        exp_d = 8'h80;  exp_ov = 1'b0;
`endif
        ifc8.in_valid = 1'b1; ifc8.in_data = 8'sd127; ifc8.in_first = 1'b1; ifc8.in_last = 1'b0;
        @(posedge clk); #1;
        ifc8.in_data = 8'sd1; ifc8.in_first = 1'b0; ifc8.in_last = 1'b1;
        @(posedge clk); #1;
        ifc8.in_valid = 1'b0;
        @(negedge clk);
        while (!ifc8.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (ifc8.out_data !== exp_d || ifc8.out_valid !== 1'b1)
            $display("FAIL sat_data: got valid %b data %0h expected valid 1 data %0h", ifc8.out_valid, ifc8.out_data, exp_d);
        else pass_cnt++;
        chk_cnt++;
        if (overflow8 !== exp_ov) $display("FAIL sat_overflow: got %b expected %b", overflow8, exp_ov); else pass_cnt++;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (overflow8 !== 1'b0) $display("FAIL sat_ovf_clear: got %b expected 0", overflow8); else pass_cnt++;
    endtask

    task automatic test_clear_and_reset();
        int st;
        psum_size = 6'd0;
        @(negedge clk);
        chk_cnt++; if (cfg_error !== 1'b1) $display("FAIL cfg_error_zero: got %b expected 1", cfg_error); else pass_cnt++;
        chk_cnt++; if (ifc.in_ready !== 1'b0) $display("FAIL cfg_in_ready: got %b expected 0", ifc.in_ready); else pass_cnt++;
        @(posedge clk); #1;
        psum_size = 6'd4;
        ifc.out_ready = 1'b0;
        send(5, 1'b1, 1'b1, st);
        send(6, 1'b1, 1'b1, st);
        repeat (2) @(negedge clk);
        chk_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL clr_pre_valid: got %b expected 1", ifc.out_valid); else pass_cnt++;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL clr_out_valid: got %b expected 0", ifc.out_valid); else pass_cnt++;
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        push_exp(0, 32'd7);
        send(7, 1'b1, 1'b1, st);
        wait_drain("clear_restart");
        ifc.out_ready = 1'b0;
        send(11, 1'b1, 1'b1, st);
        send(12, 1'b1, 1'b1, st);
        repeat (3) @(negedge clk);
        chk_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b expected 1", ifc.out_valid); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        #1;
        chk_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", ifc.out_valid); else pass_cnt++;
        chk_cnt++; if (ifc.out_data !== 32'h0) $display("FAIL rst_mid_data: got %0h expected 0", ifc.out_data); else pass_cnt++;
        chk_cnt++; if (ifc.out_addr !== 5'h0) $display("FAIL rst_mid_addr: got %0h expected 0", ifc.out_addr); else pass_cnt++;
        chk_cnt++; if (ifc.in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", ifc.in_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (ifc.out_valid !== 1'b0) $display("FAIL rst_mid_lost: got %b expected 0", ifc.out_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_back_to_back();
        test_backpressure();
        test_signed();
        test_saturate();
        test_clear_and_reset();
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/psum_accum_engine.md
Name: psum_accum_engine

Overview:
Parametrised partial-sum accumulation engine for the CNN PE, sitting between the multiplier output and the result buffer. It replaces the fixed psum scratch pad, accumulate mux and read/write address counters with one pipelined block:
- valid/ready product input,
- runtime psum length,
- per-product first/last flags,
- an output queue that drains finished sums under back-pressure.

Parameters:
MULT_WIDTH, 14, signed product width from the multiplier.
PSUM_WIDTH, 32, signed accumulator and entry width; must be >= MULT_WIDTH.
PSUM_DEPTH, 32, number of psum scratch-pad entries.
ADDR_WIDTH, $clog2(PSUM_DEPTH), entry address width.
SIZE_WIDTH, $clog2(PSUM_DEPTH+1), width of the runtime size field.
OUT_FIFO_DEPTH, 4, depth of the finished-sum queue; power of two, >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
psum_size  in  SIZE_WIDTH  live entries, 1..PSUM_DEPTH
clear  in  1  synchronous flush pulse
in_valid  in  1  product valid
in_ready  out  1  engine accepts product
in_data  in  MULT_WIDTH  signed product
in_first  in  1  accumulate onto zero, not the stored entry
in_last  in  1  final contribution; emit result
out_valid  out  1  finished sum available
out_ready  in  1  consumer accepts sum
out_data  out  PSUM_WIDTH  finished signed sum
out_addr  out  ADDR_WIDTH  entry index of out_data
block_done  out  1  pulse when entry psum_size-1 is popped
cfg_error  out  1  psum_size is 0 or > PSUM_DEPTH
overflow  out  1  sticky saturation flag

Behaviour:
Reset (rst low, asynchronous):
- Write pointer = 0, S1 valid = 0, FIFO empty, all spad entries = 0.
- Outputs: out_valid=0, block_done=0, overflow=0, in_ready=1 (when cfg_error=0).
- Outputs out_data and out_addr are 0.

Accept:
- A product is accepted on an edge where in_valid & in_ready.
- S1 registers {data, addr=ptr, first, last}.
- ptr <= (ptr == psum_size-1) ? 0 : ptr+1, so the pointer wraps every psum_size products.

S2 (the cycle S1 is valid):
- sum = (first ? 0 : spad[addr]) + sign_extend(data).
- spad[addr] <= sum at the next edge.
- If last, {addr, sum} is pushed into the FIFO at that same edge.
- out_valid is visible the cycle after the S1 cycle, i.e. two edges after acceptance when the FIFO is empty.
- S2 write at edge N and S1 read at cycle N+1 give consecutive same-address products (psum_size=1) the updated value with no stall.

Flow control:
- in_ready = !cfg_error & (fifo_count + s1_valid < OUT_FIFO_DEPTH).
- Conservative: no credit is taken for a same-cycle pop.

Output:
- A pop occurs when out_valid & out_ready; FIFO order is strictly the push order.
- block_done pulses the cycle after popping an entry with out_addr == psum_size-1.
- FIFO full and empty conditions are never violated; push on full cannot occur by construction.

clear (synchronous):
- Sets ptr=0, drops S1, empties the FIFO; block_done is not pulsed.
- The spad is not zeroed; in_first handles re-initialisation.
- clear has priority over a same-cycle accept, push and pop.

Configuration:
- psum_size may change only when ptr=0 and S1 is empty; behaviour is otherwise undefined.
- cfg_error is combinational; while it is high, in_ready=0 and accepts are blocked.

Reset mid-operation: everything returns to the reset state immediately, and the FIFO contents are lost.

Arithmetic: signed two's complement; the default add wraps modulo 2^PSUM_WIDTH.

Optional Feature:
PSUM_SATURATE_EN.
- Defined: the S2 add saturates to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1]. Any clipping sets overflow, which stays set until rst or clear.
- Undefined: the add wraps, and overflow is tied 0.

Decomposition:
- Package cnn_psum_pkg: PSUM_WIDTH/MULT_WIDTH defaults, the FIFO entry struct typedef {addr, sum}, and saturation min/max constants.
- Sub-module psum_out_fifo: synchronous FIFO with count output, parametrised by entry width and OUT_FIFO_DEPTH.
- The S1 stage, pointer and spad stay in the top.

Test Plan:
1. psum_size=4; products 1,2,3,4 with first=1; then 10,20,30,40 with last=1; out_ready=1 -> outputs (0,11),(1,22),(2,33),(3,44) in order; block_done pulses once after addr 3.
2. psum_size=1; five back-to-back products of 3; first on #1, last on #5 -> single output (0,15); no stall, in_ready stays 1.
3. OUT_FIFO_DEPTH=4, psum_size=8; eight products each first&last; out_ready=0 -> in_ready drops once fifo_count+s1_valid reaches 4. Then release out_ready -> all 8 values emitted in order, addr 0..7, none lost.
4. Products -5 (first), +2 (last), PSUM_WIDTH=32 -> out_data = 32'hFFFFFFFD (-3).
5. PSUM_WIDTH=8; 127 (first) then 1 (last) -> with PSUM_SATURATE_EN out_data=127 and overflow=1; without it out_data=-128 and overflow=0.
6. psum_size=0 -> cfg_error=1, in_ready=0. Mid-stream clear with the FIFO holding 2 entries -> out_valid=0 next cycle, ptr restarts at 0. rst low mid-drain -> all outputs return to reset values asynchronously.
